// File: rtl/scale_round_controller.sv
// rtl/scale_round_controller.sv - multi-round scaler/detector frame sequencer (optional macro: SCALE_EARLY_EXIT_EN)
module scale_round_controller #(
    parameter int NUM_ROUNDS    = 18,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       scaler_end,
    input  logic       det_finish,
    input  logic       face_detect,
    output logic       scaler_en,
    output logic [4:0] round_scale,
    output logic       busy,
    output logic       done,
    output logic       face_found
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [4:0] LAST_ROUND  = 5'(NUM_ROUNDS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_d;
    logic [3:0] settle_cnt;
    logic [3:0] settle_cnt_d;
    logic [4:0] round_d;
    logic       face_d;
    logic       scaler_en_d;
    logic       busy_d;
    logic       done_d;
    logic       last_round;
    logic       early_exit;

    assign last_round = (round_scale == LAST_ROUND);

`ifdef SCALE_EARLY_EXIT_EN
    // A face in any finished round makes the remaining scales pointless.
    assign early_exit = face_found;
`else
    assign early_exit = 1'b0;
`endif

    // State and all outputs are registered together so they always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            settle_cnt  <= 4'd0;
            round_scale <= 5'd0;
            face_found  <= 1'b0;
            scaler_en   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            settle_cnt  <= settle_cnt_d;
            round_scale <= round_d;
            face_found  <= face_d;
            scaler_en   <= scaler_en_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        state_d = state;
        if (abort && (state != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state_d = S_CLEAR;
                end
                S_CLEAR: begin
                    if (settle_cnt == SETTLE_LAST) state_d = S_SCAN;
                end
                S_SCAN: begin
                    // An early det_finish is meaningless until the scaler has finished.
                    if (scaler_end) state_d = det_finish ? S_NEXT : S_DRAIN;
                end
                S_DRAIN: begin
                    if (det_finish) state_d = S_NEXT;
                end
                S_NEXT: begin
                    state_d = (last_round || early_exit) ? S_DONE : S_CLEAR;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output values for the state being entered, loaded by the register above.
    always_comb begin
        settle_cnt_d = 4'd0;
        round_d      = round_scale;
        face_d       = face_found;
        scaler_en_d  = (state_d == S_SCAN) || (state_d == S_DRAIN);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);

        // Settle counter runs only while CLEAR is held; it is zero on entry.
        if ((state == S_CLEAR) && (state_d == S_CLEAR)) begin
            settle_cnt_d = settle_cnt + 4'd1;
        end

        // A new frame restarts the scale index and forgets old detections.
        if ((state == S_IDLE) && (state_d == S_CLEAR)) begin
            round_d = 5'd0;
            face_d  = 1'b0;
        end

        // Only NEXT->CLEAR advances the index, and that path excludes the last round.
        if ((state == S_NEXT) && (state_d == S_CLEAR)) begin
            round_d = round_scale + 5'd1;
        end

        // Detections count only while a round's windows are live.
        if (((state == S_SCAN) || (state == S_DRAIN)) && face_detect) begin
            face_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_scale_round_controller.sv
// tb/tb_scale_round_controller.sv - self-checking bench for scale_round_controller
module tb_scale_round_controller;

    localparam int NR = 18;
    localparam int SC = 2;
`ifdef SCALE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       scaler_end = 1'b0;
    logic       det_finish = 1'b0;
    logic       face_detect = 1'b0;
    logic       scaler_en;
    logic [4:0] round_scale;
    logic       busy;
    logic       done;
    logic       face_found;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    scale_round_controller #(.NUM_ROUNDS(NR), .SETTLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .scaler_end  (scaler_end),
        .det_finish  (det_finish),
        .face_detect (face_detect),
        .scaler_en   (scaler_en),
        .round_scale (round_scale),
        .busy        (busy),
        .done        (done),
        .face_found  (face_found)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({scaler_en, busy, done, face_found, round_scale} !== 9'b0) begin
            fails++;
            $display("FAIL reset_values got %b want 000000000", {scaler_en, busy, done, face_found, round_scale});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({scaler_en, busy, done} !== 3'b000 || done_cnt !== 0) begin
            fails++;
            $display("FAIL reset_idle got en/busy/done=%b dones=%0d want 000 0", {scaler_en, busy, done}, done_cnt);
        end
    endtask

    // same_mode: 0 = det_finish 5 cycles after scaler_end, 1 = same cycle, 2 = random.
    task automatic run_frame(input int face_round, input int same_mode, input int abort_round,
                             input int reset_round, input bit noise);
        int exp_rounds, low, d0, scan_n, drain_n, want_low;
        bit same, exp_face;
        exp_rounds = (EARLY && face_round >= 0) ? face_round + 1 : NR;
        exp_face   = (face_round >= 0);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if ({busy, scaler_en, face_found} !== 3'b100 || round_scale !== 5'd0) begin
            fails++;
            $display("FAIL frame_start got busy/en/face=%b round=%0d want 100 0", {busy, scaler_en, face_found}, round_scale);
        end
        for (int r = 0; r < exp_rounds; r++) begin
            low = 0;
            while (scaler_en !== 1'b1 && low < 40) begin
                face_detect = noise;
                low++;
                @(negedge clk);
            end
            face_detect = 1'b0;
            want_low = (r == 0) ? SC : SC + 1;
            tests++;
            if (low !== want_low) begin
                fails++;
                $display("FAIL low_cycles round %0d got %0d want %0d", r, low, want_low);
            end
            tests++;
            if (round_scale !== 5'(r) || busy !== 1'b1) begin
                fails++;
                $display("FAIL scan_round got round=%0d busy=%b want %0d 1", round_scale, busy, r);
            end
            if (r == reset_round) begin
                rst_n = 1'b0;
                #1;
                tests++;
                if ({scaler_en, busy, done, face_found, round_scale} !== 9'b0) begin
                    fails++;
                    $display("FAIL async_reset got %b want 000000000", {scaler_en, busy, done, face_found, round_scale});
                end
                @(negedge clk);
                rst_n = 1'b1;
                repeat (10) @(negedge clk);
                tests++;
                if (done_cnt !== d0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_no_done got dones=%0d busy=%b want %0d 0", done_cnt - d0, busy, 0);
                end
                return;
            end
            scan_n = $urandom_range(0, 4);
            for (int k = 0; k < scan_n; k++) begin
                start      = 1'($urandom_range(0, 1));
                det_finish = 1'($urandom_range(0, 1));
                @(negedge clk);
                tests++;
                if (scaler_en !== 1'b1 || round_scale !== 5'(r)) begin
                    fails++;
                    $display("FAIL scan_hold got en=%b round=%0d want 1 %0d", scaler_en, round_scale, r);
                end
            end
            start = 1'b0;
            same = (same_mode == 2) ? 1'($urandom_range(0, 1)) : (same_mode == 1);
            scaler_end  = 1'b1;
            det_finish  = same;
            face_detect = (r == face_round);
            @(negedge clk);
            scaler_end  = 1'b0;
            det_finish  = 1'b0;
            face_detect = 1'b0;
            tests++;
            if (face_found !== (exp_face && r >= face_round)) begin
                fails++;
                $display("FAIL face_flag round %0d got %b want %b", r, face_found, (exp_face && r >= face_round));
            end
            if (!same) begin
                tests++;
                if (scaler_en !== 1'b1) begin
                    fails++;
                    $display("FAIL drain_en got %b want 1", scaler_en);
                end
                if (r == abort_round) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    tests++;
                    if ({scaler_en, busy, done} !== 3'b000) begin
                        fails++;
                        $display("FAIL abort_idle got en/busy/done=%b want 000", {scaler_en, busy, done});
                    end
                    repeat (5) @(negedge clk);
                    tests++;
                    if (done_cnt !== d0 || busy !== 1'b0) begin
                        fails++;
                        $display("FAIL abort_no_done got dones=%0d busy=%b want 0 0", done_cnt - d0, busy);
                    end
                    return;
                end
                drain_n = (same_mode == 0) ? 4 : $urandom_range(0, 5);
                for (int k = 0; k < drain_n; k++) begin
                    start = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    tests++;
                    if (scaler_en !== 1'b1 || round_scale !== 5'(r)) begin
                        fails++;
                        $display("FAIL drain_hold got en=%b round=%0d want 1 %0d", scaler_en, round_scale, r);
                    end
                end
                start = 1'b0;
                det_finish = 1'b1;
                @(negedge clk);
                det_finish = 1'b0;
            end
            tests++;
            if ({scaler_en, busy, done} !== 3'b010) begin
                fails++;
                $display("FAIL next_state got en/busy/done=%b want 010", {scaler_en, busy, done});
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || round_scale !== 5'(exp_rounds - 1) || face_found !== exp_face) begin
            fails++;
            $display("FAIL done_pulse got done=%b round=%0d face=%b want 1 %0d %b", done, round_scale, face_found, exp_rounds - 1, exp_face);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || done_cnt !== d0 + 1) begin
            fails++;
            $display("FAIL frame_end got busy=%b done=%b dones=%0d want 0 0 1", busy, done, done_cnt - d0);
        end
        face_detect = 1'b1;
        repeat (3) @(negedge clk);
        face_detect = 1'b0;
        tests++;
        if (round_scale !== 5'(exp_rounds - 1) || face_found !== exp_face || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold got round=%0d face=%b busy=%b want %0d %b 0", round_scale, face_found, busy, exp_rounds - 1, exp_face);
        end
    endtask

    task automatic test_full_frame;
        run_frame(-1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_coincide;
        run_frame(-1, 1, -1, -1, 1'b0);
    endtask

    task automatic test_face;
        run_frame(3, 2, -1, -1, 1'b0);
    endtask

    task automatic test_abort;
        run_frame(-1, 0, 7, -1, 1'b0);
        run_frame(-1, 2, -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid;
        run_frame(-1, 2, -1, 10, 1'b0);
        run_frame(-1, 2, -1, -1, 1'b0);
    endtask

    task automatic test_face_ignored;
        run_frame(-1, 2, -1, -1, 1'b1);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            run_frame(int'($urandom_range(0, NR)) - 1, 2, -1, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_coincide;
        test_face;
        test_abort;
        test_reset_mid;
        test_face_ignored;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scale_round_controller.md
SCALE_ROUND_CONTROLLER -- requirements
Module: scale_round_controller

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 18, the number of scale rounds per frame (round_scale 0..NUM_ROUNDS-1, legal range 1..32).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, the number of cycles scaler_en is held low between rounds so the scaler address restarts at 0 (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: request to begin a frame; acted on only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: synchronous cancel of the frame in progress.
REQ-007 SHALL have port scaler_end, input, 1 bit: the scaler has reached its last address for the current round.
REQ-008 SHALL have port det_finish, input, 1 bit: the detector has consumed all windows for the current round.
REQ-009 SHALL have port face_detect, input, 1 bit: the detector reports a face in the current round.
REQ-010 SHALL have port scaler_en, output, 1 bit: enable to the scaler; low clears the scaler address.
REQ-011 SHALL have port round_scale, output, 5 bits: current scale index.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-014 SHALL have port face_found, output, 1 bit: sticky flag, set if any round reported a face.

Function
REQ-015 SHALL implement the states IDLE, CLEAR, SCAN, DRAIN, NEXT and DONE; all outputs SHALL be registered.
REQ-016 IDLE with start=1 SHALL go to CLEAR, set round_scale=0 and clear face_found.
REQ-017 In CLEAR, scaler_en SHALL be 0 for exactly SETTLE_CYCLES cycles, then the block SHALL go to SCAN.
REQ-018 In SCAN, scaler_en SHALL be 1; scaler_end=1 SHALL go to DRAIN, or directly to NEXT if det_finish=1 in the same cycle.
REQ-019 In DRAIN, scaler_en SHALL stay 1 (the scaler holds its last address); det_finish=1 SHALL go to NEXT.
REQ-020 det_finish arriving in SCAN before scaler_end SHALL be ignored.
REQ-021 In NEXT, scaler_en SHALL be 0; if round_scale==NUM_ROUNDS-1 the block SHALL go to DONE, otherwise it SHALL increment round_scale and go to CLEAR.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE; round_scale and face_found SHALL hold their values in IDLE.
REQ-023 face_detect=1 SHALL set face_found only while in SCAN or DRAIN, and it SHALL be ignored in every other state.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge with scaler_en=0 and no done pulse; abort SHALL take priority over every other transition.
REQ-026 round_scale SHALL never exceed NUM_ROUNDS-1 and SHALL never wrap.

Reset
REQ-027 While rst_n=0, the block SHALL immediately be in IDLE with scaler_en=0, round_scale=0, busy=0, done=0, face_found=0 and the settle counter at 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame, and no done pulse SHALL follow reset release.

Configuration
REQ-029 SHALL support the macro SCALE_EARLY_EXIT_EN: when defined, NEXT with face_found=1 SHALL go to DONE regardless of round_scale; when undefined, all NUM_ROUNDS rounds SHALL always run.

Verification
REQ-030 Run a full frame with NUM_ROUNDS=18, SETTLE_CYCLES=2, and scaler_end then det_finish 5 cycles later each round: round_scale SHALL step 0..17, scaler_en SHALL be low 2 cycles in CLEAR plus 1 cycle in NEXT between rounds, and a single done pulse SHALL occur after round 17.
REQ-031 Assert scaler_end and det_finish in the same cycle: DRAIN SHALL be skipped and NEXT SHALL follow directly.
REQ-032 Pulse face_detect in round 3 with SCALE_EARLY_EXIT_EN defined: done SHALL follow the NEXT of round 3 with face_found=1 and round_scale=3; with the macro undefined, the frame SHALL end at round 17 with face_found=1.
REQ-033 Assert abort in DRAIN of round 7: the block SHALL return to IDLE next cycle with scaler_en=0 and busy=0, with no done pulse; a new start SHALL begin at round_scale=0.
REQ-034 Pulse start in SCAN and det_finish early in SCAN: there SHALL be no effect on state or round_scale.
REQ-035 Drive rst_n low for 1 cycle mid-SCAN of round 10: outputs SHALL take their reset values asynchronously, with no done pulse afterwards.
